// File: rtl/rand_seq_share_ctrl.sv
// Shares one fixed-cycle pseudo-random sequence among N requesters through
// round-robin arbitration and a grant/ack handshake.
module rand_seq_share_ctrl #(
    parameter int N       = 4,
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic [N-1:0] ack,
    output logic [N-1:0] gnt,
    output logic         valid,
    output logic [3:0]   number,
    output logic         timeout,
    output logic [7:0]   issued
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] widx;
    logic [7:0]    timer;
    logic [PW-1:0] pick_w;
    logic [PW-1:0] ptr_after;

    function automatic logic [3:0] seq_next(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'd2:    r = 4'd1;
            4'd1:    r = 4'd7;
            4'd7:    r = 4'd9;
            4'd9:    r = 4'd8;
            4'd8:    r = 4'd4;
            4'd4:    r = 4'd11;
            4'd11:   r = 4'd14;
            default: r = 4'd2;
        endcase
        return r;
    endfunction

    // First set request at or above the pointer, wrapping around.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic          found;
        int            k;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(p) + i) % N;
            if (!found && r[k]) begin
                w     = PW'(k);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign pick_w    = rr_pick(req, ptr);
    assign ptr_after = (int'(widx) == N - 1) ? '0 : widx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            widx    <= '0;
            timer   <= '0;
            gnt     <= '0;
            valid   <= 1'b0;
            number  <= 4'd2;
            timeout <= 1'b0;
            issued  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && (|req)) begin
                        widx  <= pick_w;
                        gnt   <= N'(1) << pick_w;
                        valid <= 1'b1;
                        timer <= '0;
                        state <= OFFER;
                    end else begin
                        gnt   <= '0;
                        valid <= 1'b0;
                    end
                end
                OFFER: begin
                    // en is deliberately ignored here: an open offer always runs to completion.
                    if (ack[widx]) begin
                        number <= seq_next(number);
                        issued <= issued + 8'd1;
                        ptr    <= ptr_after;
                        gnt    <= '0;
                        valid  <= 1'b0;
                        state  <= IDLE;
                    end else if (!req[widx]) begin
                        ptr   <= ptr_after;
                        gnt   <= '0;
                        valid <= 1'b0;
                        state <= IDLE;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        ptr     <= ptr_after;
                        gnt     <= '0;
                        valid   <= 1'b0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rand_seq_share_ctrl.md
# rand_seq_share_ctrl

Controller that shares one fixed-cycle "random" sequence source (2→1→7→9→8→4→11→14→2…) among N requesters. It holds the sequence state, arbitrates round-robin between requesters, and offers the current value to the winner through a grant/ack handshake. The sequence advances only when a value is consumed. Aborted or timed-out offers leave the sequence untouched. It sits between the sequence datapath and the consumer blocks that draw pseudo-random values from it.

## Interface
- N, 4, number of requesters (2..8)
- TIMEOUT, 8, max cycles an offer is held without ack (≥1, ≤255)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  global enable; new arbitration only while high
- req  input  N  level request per requester; held until acked or abandoned
- ack  input  N  consume strobe; only ack[winner] while valid is honoured
- gnt  output  N  one-hot grant; all zero when idle
- valid  output  1  offer in progress; number is meaningful to gnt holder
- number  output  4  current sequence value (registered)
- timeout  output  1  one-cycle pulse when an offer expires
- issued  output  8  count of consumed values, wraps 255→0

## Operation
- Sequence next-state function: 2→1, 1→7, 7→9, 9→8, 8→4, 4→11, 11→14, 14→2, any other value→2.
- Reset (rst_n low, async) sets:
  - number=2, gnt=0, valid=0, timeout=0, issued=0
  - round-robin pointer=0, timer=0, FSM=IDLE
- FSM has two states: IDLE and OFFER.
- IDLE:
  - If en=1 and req≠0, pick the winner as the first set req bit searching upward from the pointer with wrap.
  - Load gnt=onehot(winner), set valid=1, clear timer, go to OFFER.
  - Otherwise stay in IDLE with outputs at zero.
- OFFER, checks in priority order:
  1. ack[winner]=1: number←next(number), issued←issued+1, pointer←winner+1 mod N, gnt=0, valid=0, go to IDLE.
  2. req[winner]=0 (abandon): number unchanged, pointer←winner+1 mod N, gnt=0, valid=0, go to IDLE.
  3. timer=TIMEOUT-1: as abandon, plus timeout=1 for one cycle.
  4. Else timer←timer+1.
- ack bits other than ack[winner], and any ack while valid=0, are ignored.
- en falling during OFFER does not cancel the offer; the transaction completes normally.
- req changes of non-winners during OFFER have no effect until the next IDLE arbitration.

## Timing
- Arbitration latency: req sampled at edge k in IDLE → gnt/valid high after edge k.
- Handshake: ack sampled at edge m while valid=1 → after edge m, valid=0, gnt=0, and number shows the next value.
- One mandatory IDLE cycle follows every offer, so maximum throughput is one value per 2 cycles.
- An offer is held at most TIMEOUT cycles. ack in the TIMEOUT-th cycle is accepted, and timeout stays 0.
- timeout is asserted in the cycle after the final offer cycle, coincident with the return to IDLE.
- number is stable for the whole of an offer.
- rst_n asserted mid-offer immediately clears gnt and valid and returns number to 2; no partial advance.
- issued is modulo-256 with no saturation.

## Test plan
- Reset values: assert rst_n=0 asynchronously between edges → outputs drop at once to number=2, gnt=0, valid=0, timeout=0, issued=0.
- Single requester:
  - Stimulus: req=0001, en=1, ack asserted on the first valid cycle, 8 times.
  - Response: values offered are 2,1,7,9,8,4,11,14; number back to 2; issued=8; gnt=0001 every other cycle.
- Round-robin fairness:
  - Stimulus: req=1111 held, immediate acks.
  - Response: gnt order 0001,0010,0100,1000,0001, values 2,1,7,9,8.
- Timeout:
  - Stimulus: req=0011, never ack.
  - Response: valid held exactly TIMEOUT=8 cycles with gnt=0001, then a timeout pulse, number still 2, next offer gnt=0010 with value 2.
- Abandon and stray ack:
  - Stimulus: during an offer to requester 2, assert ack[1], then drop req[2].
  - Response: ack[1] ignored, offer withdrawn next edge, number unchanged, issued unchanged, timeout=0.
- en gating and reset mid-offer:
  - Stimulus: en=0 with req=1111.
  - Response: no grant.
  - Stimulus: en drops during an offer.
  - Response: offer still completes on ack.
  - Stimulus: rst_n pulses with number=9 during an offer.
  - Response: number=2, valid=0, pointer=0.
